ms_gather_relay: RTL and testbench
==================================

Name: ms_gather_relay

Overview:
- Parametrised successor of the two-section master/slave skeleton blocks.
- Gathers values from N_CH blocking slave input channels, each with a sync flag, using a round-robin arbiter.
- Forwards each gathered value on a master output with a one-cycle notify pulse, in either pass-through-with-offset or running-accumulate mode.
- Exposes the last consumed value and a transfer counter as shared outputs for the surrounding system model.

Parameters:
- DATA_W, 32, width of all data paths.
- N_CH, 2, number of slave input channels (1..16).
- MODE, 0, 0 = forward value + m_in offset; 1 = forward running sum of consumed values.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_in  input  DATA_W  offset operand; sampled in SEC_B, MODE 0 only.
- m_out  output  DATA_W  master data; valid while m_out_notify=1, holds value otherwise.
- m_out_notify  output  1  one-cycle write strobe for m_out.
- s_in  input  N_CH*DATA_W  slave data; channel i is bits [i*DATA_W +: DATA_W].
- s_in_sync  input  N_CH  per-channel data-valid.
- s_in_taken  output  N_CH  one-hot, one-cycle pulse: channel consumed.
- s_out  output  DATA_W  last consumed raw value.
- s_out_ch  output  clog2(N_CH) (min 1)  channel index of last consumed value.
- shared_out  output  CNT_W  number of completed transfers.

Behaviour:
- Reset (async, rst=1):
  - section=SEC_A; save_val=0; acc=0; ptr=0.
  - m_out=0, m_out_notify=0, s_in_taken=0, s_out=0, s_out_ch=0, shared_out=0.
- SEC_A (sample):
  - m_out_notify and s_in_taken clear to 0 every edge spent in SEC_A.
  - If no s_in_sync bit is set: stay in SEC_A; nothing else changes.
  - Otherwise grant the first set sync bit at or after ptr, searching upward and wrapping modulo N_CH.
  - On the grant edge: save_val <= granted data; sel <= granted index; s_in_taken[sel] <= 1; section <= SEC_B.
  - Exactly one channel is granted per visit.
- SEC_B (emit), one cycle, unconditional:
  - s_in_taken <= 0.
  - MODE 0: m_out <= save_val + m_in.
  - MODE 1: acc <= acc + save_val; m_out <= acc + save_val.
  - All sums wrap modulo 2^DATA_W.
  - m_out_notify <= 1; s_out <= save_val; s_out_ch <= sel.
  - shared_out <= shared_out + 1, wrapping to 0 at 2^CNT_W.
  - ptr <= (sel + 1) mod N_CH; section <= SEC_A.
- Latency:
  - Sync seen at edge k gives s_in_taken high after edge k; m_out/m_out_notify valid after edge k+1; notify drops after edge k+2.
  - Peak throughput is one transfer per 2 cycles.
- Source handshake:
  - Sources hold s_in/s_in_sync until they observe s_in_taken.
  - Sync deasserted before being granted is simply missed; it is not an error.
  - Sync still high in SEC_B is ignored.
  - Sync still high at the next SEC_A edge is a new request, so sources drop sync after taken.
- Fairness: with all channels continuously requesting, grants cycle 0,1,...,N_CH-1,0,...
- N_CH=1: ptr is constant 0; the arbiter degenerates to a direct take.
- Reset mid-transfer (e.g. in SEC_B): the transfer is abandoned; no notify; counter and acc return to 0.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset, then ch0 sync with s_in[ch0]=0x10, m_in=5, MODE 0:
  - s_in_taken=01 one cycle.
  - Next cycle m_out=0x15, notify=1 for exactly one cycle.
  - s_out=0x10, s_out_ch=0, shared_out=1.
- N_CH=4, all sync held high, values 1,2,3,4: grant order 0,1,2,3,0; five notifies spaced 2 cycles apart; shared_out=5.
- MODE 1, values 0xFFFFFFFF then 2 on ch1: m_out=0xFFFFFFFF, then 0x00000001 (wrap); shared_out=2.
- CNT_W=2: five transfers give shared_out sequence 1,2,3,0,1.
- Assert rst during SEC_B after ch1 taken: no notify appears; all outputs 0; next ch1 request with value 7 gives m_out=7+m_in, shared_out=1.
- Idle, all sync=0 for 20 cycles: section stays SEC_A; notify, taken and shared_out unchanged.

Source files
------------

// File: rtl/ms_gather_relay_if.sv
// Bundle of the relay's data/handshake signals. The master modport is the relay's view;
// the slave modport is the surrounding system that feeds and observes it.
interface ms_gather_relay_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [DATA_W-1:0]      m_in;
  logic [DATA_W-1:0]      m_out;
  logic                   m_out_notify;
  logic [N_CH*DATA_W-1:0] s_in;
  logic [N_CH-1:0]        s_in_sync;
  logic [N_CH-1:0]        s_in_taken;
  logic [DATA_W-1:0]      s_out;
  logic [CH_W-1:0]        s_out_ch;
  logic [CNT_W-1:0]       shared_out;

  modport master (
    input  m_in, s_in, s_in_sync,
    output m_out, m_out_notify, s_in_taken, s_out, s_out_ch, shared_out
  );

  modport slave (
    output m_in, s_in, s_in_sync,
    input  m_out, m_out_notify, s_in_taken, s_out, s_out_ch, shared_out
  );
endinterface

// File: rtl/ms_gather_relay.sv
// Round-robin gather of N_CH synced slave channels, relayed to a master output either as
// value+offset (MODE 0) or as a running sum (MODE 1), one transfer per two cycles at most.
module ms_gather_relay #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ms_gather_relay_if.master bus
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {SEC_A, SEC_B} section_e;

  section_e          section_q, section_d;
  logic [DATA_W-1:0] save_val_q, save_val_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] m_out_q, m_out_d;
  logic              m_out_notify_q, m_out_notify_d;
  logic [N_CH-1:0]   taken_q, taken_d;
  logic [DATA_W-1:0] s_out_q, s_out_d;
  logic [CH_W-1:0]   s_out_ch_q, s_out_ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic [DATA_W-1:0] grant_data;
  logic [N_CH-1:0]   sync_shift;
  int unsigned       idx;

  // Arbiter: first set sync bit at or after ptr, searching upward and wrapping.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    idx        = 0;
    sync_shift = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx        = (32'(ptr_q) + i) % N_CH;
      sync_shift = bus.s_in_sync >> idx;
      if (!grant_vld && sync_shift[0]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
    grant_data = DATA_W'(bus.s_in >> (32'(grant_idx) * DATA_W));
  end

  // Section sequencing and output computation.
  always_comb begin
    section_d      = section_q;
    save_val_d     = save_val_q;
    acc_d          = acc_q;
    sel_d          = sel_q;
    ptr_d          = ptr_q;
    m_out_d        = m_out_q;
    m_out_notify_d = m_out_notify_q;
    taken_d        = taken_q;
    s_out_d        = s_out_q;
    s_out_ch_d     = s_out_ch_q;
    cnt_d          = cnt_q;
    case (section_q)
      SEC_A: begin
        m_out_notify_d = 1'b0;
        taken_d        = '0;
        if (grant_vld) begin
          save_val_d = grant_data;
          sel_d      = grant_idx;
          taken_d    = N_CH'(1) << grant_idx;
          section_d  = SEC_B;
        end
      end
      SEC_B: begin
        taken_d = '0;
        if (MODE == 1) begin
          acc_d   = acc_q + save_val_q;
          m_out_d = acc_q + save_val_q;
        end else begin
          m_out_d = save_val_q + bus.m_in;
        end
        m_out_notify_d = 1'b1;
        s_out_d        = save_val_q;
        s_out_ch_d     = sel_q;
        cnt_d          = cnt_q + CNT_W'(1);
        ptr_d          = (N_CH == 1) ? '0 : CH_W'((32'(sel_q) + 1) % N_CH);
        section_d      = SEC_A;
      end
      default: section_d = SEC_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q      <= SEC_A;
      save_val_q     <= '0;
      acc_q          <= '0;
      sel_q          <= '0;
      ptr_q          <= '0;
      m_out_q        <= '0;
      m_out_notify_q <= 1'b0;
      taken_q        <= '0;
      s_out_q        <= '0;
      s_out_ch_q     <= '0;
      cnt_q          <= '0;
    end else begin
      section_q      <= section_d;
      save_val_q     <= save_val_d;
      acc_q          <= acc_d;
      sel_q          <= sel_d;
      ptr_q          <= ptr_d;
      m_out_q        <= m_out_d;
      m_out_notify_q <= m_out_notify_d;
      taken_q        <= taken_d;
      s_out_q        <= s_out_d;
      s_out_ch_q     <= s_out_ch_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.m_out        = m_out_q;
  assign bus.m_out_notify = m_out_notify_q;
  assign bus.s_in_taken   = taken_q;
  assign bus.s_out        = s_out_q;
  assign bus.s_out_ch     = s_out_ch_q;
  assign bus.shared_out   = cnt_q;
endmodule

// File: tb/tb_ms_gather_relay.sv
// Scoreboard bench for ms_gather_relay: three instances cover 4-channel offset mode,
// 2-channel accumulate mode and a single-channel relay with a 2-bit transfer counter.
module tb_ms_gather_relay;
  logic clk;
  logic rst;

  typedef struct {
    logic [31:0] m_out;
    logic [31:0] s_out;
    int unsigned ch;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  ms_gather_relay_if #(.DATA_W(32), .N_CH(4), .CNT_W(16)) b0 ();
  ms_gather_relay_if #(.DATA_W(32), .N_CH(2), .CNT_W(16)) b1 ();
  ms_gather_relay_if #(.DATA_W(32), .N_CH(1), .CNT_W(2))  b2 ();

  ms_gather_relay #(.DATA_W(32), .N_CH(4), .MODE(0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0.master));
  ms_gather_relay #(.DATA_W(32), .N_CH(2), .MODE(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1.master));
  ms_gather_relay #(.DATA_W(32), .N_CH(1), .MODE(0), .CNT_W(2))  u2 (.clk(clk), .rst(rst), .bus(b2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b0.m_in = '0; b0.s_in = '0; b0.s_in_sync = '0;
    b1.m_in = '0; b1.s_in = '0; b1.s_in_sync = '0;
    b2.m_in = '0; b2.s_in = '0; b2.s_in_sync = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #3;
    n_cmp++;
    if ({b0.m_out, b0.m_out_notify, b0.s_in_taken, b0.s_out, b0.s_out_ch, b0.shared_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_u0: got m_out=%h notify=%b taken=%b s_out=%h ch=%0d cnt=%0d, want all zero",
               b0.m_out, b0.m_out_notify, b0.s_in_taken, b0.s_out, b0.s_out_ch, b0.shared_out);
    end
    n_cmp++;
    if ({b1.m_out, b1.m_out_notify, b1.s_in_taken, b1.shared_out,
         b2.m_out, b2.m_out_notify, b2.s_in_taken, b2.shared_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_u1_u2: got u1 m_out=%h cnt=%0d u2 m_out=%h cnt=%0d, want all zero",
               b1.m_out, b1.shared_out, b2.m_out, b2.shared_out);
    end
    apply_reset();
  endtask

  task automatic test_single();
    exp_t e;
    apply_reset();
    b0.m_in = 32'd5;
    b0.s_in[31:0] = 32'h10;
    b0.s_in_sync = 4'b0001;
    tick();
    n_cmp++;
    if (b0.s_in_taken !== 4'b0001 || b0.m_out_notify !== 1'b0) begin
      n_bad++;
      $display("FAIL single_taken: got taken=%b notify=%b, want 0001/0", b0.s_in_taken, b0.m_out_notify);
    end
    sb.push_back('{32'h15, 32'h10, 0, 1});
    b0.s_in_sync = '0;
    tick();
    n_cmp++;
    if (b0.m_out_notify !== 1'b1 || b0.s_in_taken !== 4'b0000 || sb.size() == 0) begin
      n_bad++;
      $display("FAIL single_notify: got notify=%b taken=%b, want 1/0000", b0.m_out_notify, b0.s_in_taken);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (b0.m_out !== e.m_out || b0.s_out !== e.s_out || 32'(b0.s_out_ch) !== e.ch || 32'(b0.shared_out) !== e.cnt) begin
        n_bad++;
        $display("FAIL single_emit: got m_out=%h s_out=%h ch=%0d cnt=%0d, want %h %h %0d %0d",
                 b0.m_out, b0.s_out, b0.s_out_ch, b0.shared_out, e.m_out, e.s_out, e.ch, e.cnt);
      end
    end
    tick();
    n_cmp++;
    if (b0.m_out_notify !== 1'b0 || b0.m_out !== 32'h15) begin
      n_bad++;
      $display("FAIL single_hold: got notify=%b m_out=%h, want 0/00000015", b0.m_out_notify, b0.m_out);
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    logic [3:0] exp_tk;
    apply_reset();
    b0.m_in = 32'h100;
    for (int c = 0; c < 4; c++) b0.s_in[c*32 +: 32] = 32'(c + 1);
    b0.s_in_sync = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_tk = 4'd1 << (i % 4);
      n_cmp++;
      if (b0.s_in_taken !== exp_tk || b0.m_out_notify !== 1'b0) begin
        n_bad++;
        $display("FAIL fair_grant%0d: got taken=%b notify=%b, want %b/0", i, b0.s_in_taken, b0.m_out_notify, exp_tk);
      end
      sb.push_back('{32'h100 + 32'(i % 4 + 1), 32'(i % 4 + 1), 32'(i % 4), 32'(i + 1)});
      if (i == 4) b0.s_in_sync = '0;
      tick();
      if (b0.m_out_notify !== 1'b1 || sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fair_notify%0d: got notify=%b, want 1", i, b0.m_out_notify);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (b0.m_out !== e.m_out || b0.s_out !== e.s_out || 32'(b0.s_out_ch) !== e.ch || 32'(b0.shared_out) !== e.cnt) begin
          n_bad++;
          $display("FAIL fair_emit%0d: got m_out=%h s_out=%h ch=%0d cnt=%0d, want %h %h %0d %0d",
                   i, b0.m_out, b0.s_out, b0.s_out_ch, b0.shared_out, e.m_out, e.s_out, e.ch, e.cnt);
        end
      end
    end
  endtask

  task automatic test_accumulate();
    exp_t e;
    logic [31:0] vals [2];
    logic [31:0] acc_m;
    vals[0] = 32'hFFFF_FFFF;
    vals[1] = 32'h0000_0002;
    acc_m = '0;
    apply_reset();
    b1.m_in = 32'hDEAD_0000;
    for (int i = 0; i < 2; i++) begin
      b1.s_in[63:32] = vals[i];
      b1.s_in_sync = 2'b10;
      tick();
      n_cmp++;
      if (b1.s_in_taken !== 2'b10) begin
        n_bad++;
        $display("FAIL acc_taken%0d: got %b, want 10", i, b1.s_in_taken);
      end
      acc_m = acc_m + vals[i];
      sb.push_back('{acc_m, vals[i], 1, 32'(i + 1)});
      b1.s_in_sync = '0;
      tick();
      if (b1.m_out_notify !== 1'b1 || sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL acc_notify%0d: got notify=%b, want 1", i, b1.m_out_notify);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (b1.m_out !== e.m_out || b1.s_out !== e.s_out || 32'(b1.s_out_ch) !== e.ch || 32'(b1.shared_out) !== e.cnt) begin
          n_bad++;
          $display("FAIL acc_emit%0d: got m_out=%h s_out=%h ch=%0d cnt=%0d, want %h %h %0d %0d",
                   i, b1.m_out, b1.s_out, b1.s_out_ch, b1.shared_out, e.m_out, e.s_out, e.ch, e.cnt);
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    exp_t e;
    logic [31:0] v;
    apply_reset();
    b2.m_in = 32'h1;
    for (int i = 0; i < 5; i++) begin
      v = 32'h20 + 32'(i);
      b2.s_in = v;
      b2.s_in_sync = 1'b1;
      tick();
      n_cmp++;
      if (b2.s_in_taken !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap_taken%0d: got %b, want 1", i, b2.s_in_taken);
      end
      sb.push_back('{v + 32'h1, v, 0, 32'((i + 1) % 4)});
      b2.s_in_sync = 1'b0;
      tick();
      if (b2.m_out_notify !== 1'b1 || sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wrap_notify%0d: got notify=%b, want 1", i, b2.m_out_notify);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (b2.m_out !== e.m_out || b2.s_out !== e.s_out || 32'(b2.s_out_ch) !== e.ch || 32'(b2.shared_out) !== e.cnt) begin
          n_bad++;
          $display("FAIL wrap_emit%0d: got m_out=%h s_out=%h ch=%0d cnt=%0d, want %h %h %0d %0d",
                   i, b2.m_out, b2.s_out, b2.s_out_ch, b2.shared_out, e.m_out, e.s_out, e.ch, e.cnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    b0.m_in = 32'd3;
    b0.s_in[63:32] = 32'd9;
    b0.s_in_sync = 4'b0010;
    tick();
    n_cmp++;
    if (b0.s_in_taken !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_taken: got %b, want 0010", b0.s_in_taken);
    end
    b0.s_in_sync = '0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({b0.m_out, b0.m_out_notify, b0.s_in_taken, b0.s_out, b0.s_out_ch, b0.shared_out} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got m_out=%h notify=%b taken=%b s_out=%h cnt=%0d, want all zero",
               b0.m_out, b0.m_out_notify, b0.s_in_taken, b0.s_out, b0.shared_out);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (b0.m_out_notify !== 1'b0 || b0.shared_out !== 16'd0) begin
        n_bad++;
        $display("FAIL mid_abandon%0d: got notify=%b cnt=%0d, want 0/0", i, b0.m_out_notify, b0.shared_out);
      end
    end
    b0.s_in[63:32] = 32'd7;
    b0.s_in_sync = 4'b0010;
    tick();
    n_cmp++;
    if (b0.s_in_taken !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_retake: got %b, want 0010", b0.s_in_taken);
    end
    sb.push_back('{32'd10, 32'd7, 1, 1});
    b0.s_in_sync = '0;
    tick();
    if (b0.m_out_notify !== 1'b1 || sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mid_notify: got notify=%b, want 1", b0.m_out_notify);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (b0.m_out !== e.m_out || b0.s_out !== e.s_out || 32'(b0.s_out_ch) !== e.ch || 32'(b0.shared_out) !== e.cnt) begin
        n_bad++;
        $display("FAIL mid_emit: got m_out=%h s_out=%h ch=%0d cnt=%0d, want %h %h %0d %0d",
                 b0.m_out, b0.s_out, b0.s_out_ch, b0.shared_out, e.m_out, e.s_out, e.ch, e.cnt);
      end
    end
  endtask

  task automatic test_idle();
    b0.s_in_sync = '0;
    b0.s_in = {4{32'hA5A5_A5A5}};
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (b0.m_out_notify !== 1'b0 || b0.s_in_taken !== 4'b0000 || b0.shared_out !== 16'd1 || b0.m_out !== 32'd10) begin
        n_bad++;
        $display("FAIL idle%0d: got notify=%b taken=%b cnt=%0d m_out=%h, want 0/0000/1/0000000a",
                 i, b0.m_out_notify, b0.s_in_taken, b0.shared_out, b0.m_out);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_accumulate();
    test_counter_wrap();
    test_reset_mid();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
